// File: rtl/cnn_sequencer.sv
// cnn_sequencer: drives a shared MAC through a 3x3 conv over a 5x5 image, a 9x10 FC layer and an argmax.
module cnn_sequencer (
   input  logic               CLK,
   input  logic               RST,
   input  logic               START,
   input  logic               MAC_READY,
   input  logic               ACC_VALID,
   input  logic signed [15:0] ACC,
   output logic               MAC_VALID,
   output logic               MAC_FIRST,
   output logic               MAC_LAST,
   output logic [4:0]         PIX_ADDR,
   output logic [3:0]         KW_ADDR,
   output logic [3:0]         FEAT_ADDR,
   output logic               FEAT_WE,
   output logic [6:0]         FCW_ADDR,
   output logic               BUSY,
   output logic               DONE,
   output logic [3:0]         OUT
);
   localparam logic [2:0] IDLE = 3'd0, CONV = 3'd1, CONV_WAIT = 3'd2, FC = 3'd3, FC_WAIT = 3'd4, FINISH = 3'd5;
   logic [2:0] state;
   logic [3:0] w, t, k, f, best_idx;
   logic signed [15:0] best;
   logic [3:0] r, c, kr, kc;
   always_comb begin
      r = (w >= 4'd6) ? 4'd2 : (w >= 4'd3) ? 4'd1 : 4'd0;
      c = w - (r << 1) - r;
      kr = (t >= 4'd6) ? 4'd2 : (t >= 4'd3) ? 4'd1 : 4'd0;
      kc = t - (kr << 1) - kr;
   end
   assign MAC_VALID = (state == CONV) || (state == FC);
   assign MAC_FIRST = MAC_VALID && ((state == CONV) ? (t == 4'd0) : (f == 4'd0));
   assign MAC_LAST  = MAC_VALID && ((state == CONV) ? (t == 4'd8) : (f == 4'd8));
   assign PIX_ADDR  = 5'((r + kr) * 5 + c + kc);
   assign KW_ADDR   = t;
   assign FEAT_ADDR = (state == FC) ? f : w;
   assign FEAT_WE   = (state == CONV_WAIT) && ACC_VALID;
   assign FCW_ADDR  = 7'(k * 9 + f);
   assign BUSY      = state != IDLE;
   assign DONE      = state == FINISH;
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         w <= '0;
         t <= '0;
         k <= '0;
         f <= '0;
         best <= '0;
         best_idx <= '0;
         OUT <= '0;
      end else begin
         case (state)
            IDLE: if (START) begin
               state <= CONV;
               w <= '0;
               t <= '0;
            end
            CONV: if (MAC_READY) begin
               if (t == 4'd8) state <= CONV_WAIT;
               else t <= t + 4'd1;
            end
            CONV_WAIT: if (ACC_VALID) begin
               t <= '0;
               f <= '0;
               if (w == 4'd8) begin
                  state <= FC;
                  k <= '0;
               end else begin
                  state <= CONV;
                  w <= w + 4'd1;
               end
            end
            FC: if (MAC_READY) begin
               if (f == 4'd8) state <= FC_WAIT;
               else f <= f + 4'd1;
            end
            FC_WAIT: if (ACC_VALID) begin
               // strict compare keeps the lower class index on ties
               if (k == 4'd0 || ACC > best) begin
                  best <= ACC;
                  best_idx <= k;
               end
               if (k == 4'd9) state <= FINISH;
               else begin
                  state <= FC;
                  k <= k + 4'd1;
                  f <= '0;
               end
            end
            FINISH: begin
               OUT <= best_idx;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cnn_sequencer.sv
// tb_cnn_sequencer: scoreboard bench; expected beats, feature writes and class are queued per run and popped as the DUT produces them.
module tb_cnn_sequencer;
   logic CLK = 1'b0, RST, START, MAC_READY, ACC_VALID;
   logic signed [15:0] ACC;
   logic MAC_VALID, MAC_FIRST, MAC_LAST, FEAT_WE, BUSY, DONE;
   logic [4:0] PIX_ADDR;
   logic [3:0] KW_ADDR, FEAT_ADDR, OUT;
   logic [6:0] FCW_ADDR;
   int errors = 0, checks = 0;
   logic [10:0] conv_q[$];
   logic [12:0] fc_q[$];
   logic [3:0] feat_q[$];
   logic signed [15:0] score[10];

   cnn_sequencer dut (
      .CLK(CLK), .RST(RST), .START(START), .MAC_READY(MAC_READY), .ACC_VALID(ACC_VALID), .ACC(ACC),
      .MAC_VALID(MAC_VALID), .MAC_FIRST(MAC_FIRST), .MAC_LAST(MAC_LAST), .PIX_ADDR(PIX_ADDR),
      .KW_ADDR(KW_ADDR), .FEAT_ADDR(FEAT_ADDR), .FEAT_WE(FEAT_WE), .FCW_ADDR(FCW_ADDR),
      .BUSY(BUSY), .DONE(DONE), .OUT(OUT)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic load_expected();
      logic [4:0] pix;
      logic [3:0] kw, ff;
      logic [6:0] fa;
      conv_q.delete();
      fc_q.delete();
      feat_q.delete();
      for (int w = 0; w < 9; w++) begin
         for (int t = 0; t < 9; t++) begin
            pix = 5'((w / 3 + t / 3) * 5 + w % 3 + t % 3);
            kw = 4'(t);
            conv_q.push_back({t == 0, t == 8, pix, kw});
         end
         feat_q.push_back(4'(w));
      end
      for (int k = 0; k < 10; k++)
         for (int f = 0; f < 9; f++) begin
            ff = 4'(f);
            fa = 7'(k * 9 + f);
            fc_q.push_back({f == 0, f == 8, ff, fa});
         end
   endtask

   function automatic logic [3:0] best_class();
      int b = 0;
      for (int k = 1; k < 10; k++) if (score[k] > score[b]) b = k;
      return 4'(b);
   endfunction

   task automatic run(input bit stall, input bit spur, input int abort_k, output int lat);
      int beats = 0, fc_res = 0, fwe = 0, cyc = 0;
      bit pend = 0, pend_fc = 0, done_seen = 0, aborted = 0;
      lat = -1;
      load_expected();
      @(negedge CLK);
      START = 1'b1;
      MAC_READY = 1'b0;
      ACC_VALID = 1'b0;
      while (!done_seen && !aborted && cyc < 3000) begin
         @(negedge CLK);
         cyc++;
         START = spur && (cyc % 7 == 0);
         MAC_READY = stall ? (cyc % 2 == 0) : 1'b1;
         ACC_VALID = pend || (spur && !pend && MAC_VALID && beats < 81 && cyc % 5 == 0);
         ACC = (pend && pend_fc) ? score[fc_res] : 16'sh7fff;
         if (abort_k >= 0 && fc_res == abort_k && MAC_VALID && beats >= 81) begin
            RST = 1'b1;
            START = 1'b1;
            ACC_VALID = 1'b1;
            @(negedge CLK);
            RST = 1'b0;
            START = 1'b0;
            ACC_VALID = 1'b0;
            #1;
            check("abort_busy", BUSY, 0);
            check("abort_done", DONE, 0);
            check("abort_out", OUT, 0);
            check("abort_mac_valid", MAC_VALID, 0);
            @(negedge CLK);
            #1;
            check("abort_idle", BUSY, 0);
            aborted = 1;
         end else begin
            #1;
            if (pend && pend_fc) fc_res++;
            pend = 0;
            if (MAC_VALID) begin
               if (beats < 81) begin
                  check("conv_beat", {MAC_FIRST, MAC_LAST, PIX_ADDR, KW_ADDR}, conv_q.size() ? conv_q[0] : 11'h7ff);
                  if (MAC_READY && conv_q.size()) void'(conv_q.pop_front());
               end else begin
                  check("fc_beat", {MAC_FIRST, MAC_LAST, FEAT_ADDR, FCW_ADDR}, fc_q.size() ? fc_q[0] : 13'h1fff);
                  if (MAC_READY && fc_q.size()) void'(fc_q.pop_front());
               end
               if (MAC_READY) begin
                  pend = MAC_LAST;
                  pend_fc = beats >= 81;
                  beats++;
               end
            end
            if (FEAT_WE) begin
               fwe++;
               check("feat_we_addr", FEAT_ADDR, feat_q.size() ? feat_q.pop_front() : 4'hf);
            end
            if (DONE) begin
               done_seen = 1;
               lat = cyc;
               check("busy_at_done", BUSY, 1);
            end
         end
      end
      START = 1'b0;
      ACC_VALID = 1'b0;
      MAC_READY = 1'b0;
      if (!aborted) begin
         check("done_seen", done_seen, 1);
         check("beat_count", beats, 171);
         check("feat_we_count", fwe, 9);
         @(negedge CLK);
         #1;
         check("done_one_cycle", DONE, 0);
         check("busy_after", BUSY, 0);
         check("out_class", OUT, best_class());
      end
   endtask

   initial begin
      int lat;
      RST = 1'b1;
      START = 1'b1;
      MAC_READY = 1'b1;
      ACC_VALID = 1'b1;
      ACC = '0;
      repeat (2) @(negedge CLK);
      #1;
      check("rst_busy", BUSY, 0);
      check("rst_mac_valid", MAC_VALID, 0);
      check("rst_done", DONE, 0);
      check("rst_out", OUT, 0);
      check("rst_feat_we", FEAT_WE, 0);
      RST = 1'b0;
      START = 1'b0;
      ACC_VALID = 1'b0;
      score = '{16'sd5, 16'sd9, 16'sd3, 16'sd1, 16'sd0, -16'sd2, 16'sd4, 16'sd8, 16'sd7, 16'sd6};
      run(0, 0, -1, lat);
      check("latency", lat, 191);
      check("out_free", OUT, 1);
      run(1, 0, -1, lat);
      check("out_stall", OUT, 1);
      run(0, 1, -1, lat);
      check("out_spurious", OUT, 1);
      score = '{default: -16'sd7};
      run(0, 0, -1, lat);
      check("out_all_neg", OUT, 0);
      score = '{-16'sd50, 16'sd20, 16'sd100, 16'sd99, -16'sd1, 16'sd0, 16'sd100, 16'sd3, -16'sd100, 16'sd7};
      run(1, 0, -1, lat);
      check("out_tie", OUT, 2);
      score = '{16'sd5, 16'sd9, 16'sd3, 16'sd1, 16'sd0, -16'sd2, 16'sd4, 16'sd8, 16'sd7, 16'sd6};
      run(0, 0, 4, lat);
      run(0, 0, -1, lat);
      check("latency_after_abort", lat, 191);
      check("out_after_abort", OUT, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cnn_sequencer.md
CNN_SEQUENCER -- requirements
Module: cnn_sequencer

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high.
REQ-002 Ports, clock and reset first (name, direction, width, meaning):
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous active-high reset
- START  in  1  begin one inference; sampled in IDLE only
- MAC_READY  in  1  datapath accepts the current beat
- ACC_VALID  in  1  ACC holds the finished dot product
- ACC  in  16  signed accumulated result
- MAC_VALID  out  1  beat offered to the datapath
- MAC_FIRST  out  1  first beat of a dot product; datapath clears its accumulator
- MAC_LAST  out  1  last beat of a dot product
- PIX_ADDR  out  5  image pixel index, 0..24 (row*5+col)
- KW_ADDR  out  4  conv kernel tap, 0..8
- FEAT_ADDR  out  4  feature index, 0..8 (write in CONV_WAIT, read in FC)
- FEAT_WE  out  1  feature write strobe
- FCW_ADDR  out  7  FC weight index, 0..89 (class*9+feature)
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle completion pulse
- OUT  out  4  predicted class, 0..9, held between runs

Function
REQ-003 SHALL use states IDLE, CONV, CONV_WAIT, FC, FC_WAIT, FINISH.
REQ-004 IDLE: START=1 -> CONV, window w=0, tap t=0. START is ignored in all other states.
REQ-005 CONV: MAC_VALID=1; w=0..8 (r=w/3, c=w%3); t=0..8 (kr=t/3, kc=t%3); PIX_ADDR=(r+kr)*5+(c+kc); KW_ADDR=t; MAC_FIRST=(t==0); MAC_LAST=(t==8).
REQ-006 A beat transfers only on MAC_VALID&&MAC_READY; the address and t hold while MAC_READY=0.
REQ-007 Accepted beat with t<8 -> t+1. Accepted beat with t==8 -> CONV_WAIT, MAC_VALID=0.
REQ-008 CONV_WAIT: on ACC_VALID=1, FEAT_WE=1 for exactly that cycle with FEAT_ADDR=w. Next state is CONV with w+1, t=0 if w<8; otherwise FC with class k=0, feature f=0.
REQ-009 FC: MAC_VALID=1; FEAT_ADDR=f; FCW_ADDR=k*9+f; MAC_FIRST=(f==0); MAC_LAST=(f==8). Handshake as REQ-006.
REQ-010 Accepted beat with f==8 -> FC_WAIT.
REQ-011 FC_WAIT: on ACC_VALID=1, compare ACC against the best score.
- k==0 loads unconditionally.
- k>0 replaces only if ACC is strictly greater (signed); ties keep the lower index.
- Next state is FC with k+1, f=0 if k<9; otherwise FINISH.
REQ-012 FINISH: DONE=1 for one cycle, OUT<=best index, then IDLE next cycle.
REQ-013 ACC_VALID outside CONV_WAIT/FC_WAIT SHALL be ignored; FEAT_WE SHALL never assert outside CONV_WAIT.
REQ-014 MAC_VALID=0 in IDLE, CONV_WAIT, FC_WAIT and FINISH.
REQ-015 Address outputs are don't-care when MAC_VALID=0 and FEAT_WE=0.
REQ-016 The best score is a signed 16-bit register; the best index is 4 bits.
REQ-017 Counters SHALL never exceed their ranges (w,t,f 0..8; k 0..9); no wrap beyond those ranges.
REQ-018 Run length: 81 conv beats and 90 FC beats.
REQ-019 Minimum START-to-DONE latency, with MAC_READY=1 and ACC_VALID one cycle after the last beat: 9*(9+1) + 10*(9+1) + 1 = 191 cycles.

Reset
REQ-020 RST=1 at a clock edge forces IDLE, all counters 0, best score/index 0, OUT=0, DONE=0, BUSY=0, MAC_VALID=0, FEAT_WE=0, regardless of state.
REQ-021 RST SHALL have priority over START and ACC_VALID in the same cycle.
REQ-022 A run aborted by RST produces no DONE and does not update OUT.

Verification
REQ-023 Free-flowing run: MAC_READY=1, ACC_VALID 1 cycle after each MAC_LAST, class scores 5,9,3,... -> DONE at cycle 191, OUT=1, 81 CONV beats, 9 FEAT_WE pulses at FEAT_ADDR 0..8.
REQ-024 Address sweep: window 4 -> PIX_ADDR sequence 6,7,8,11,12,13,16,17,18; class 3 -> FCW_ADDR 27..35.
REQ-025 Backpressure: MAC_READY toggling 1/0 -> address held during stalls, beat counts unchanged, same OUT as REQ-023.
REQ-026 Tie and negatives: scores all -7 -> OUT=0; score 100 at classes 2 and 6 -> OUT=2.
REQ-027 Reset mid-FC at k=4:
- -> next cycle IDLE with BUSY=0 and OUT=0, no DONE;
- a subsequent START completes normally.
REQ-028 Spurious inputs: START while BUSY and ACC_VALID during CONV -> no restart and no FEAT_WE; results identical to REQ-023.
